// File: rtl/carry_save_adder_if.sv
// Operand/result bundle for carry_save_adder: the producer drives operands,
// the adder drives the registered result back.
interface carry_save_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH:0]   sum;
    logic             out_valid;

    modport master (
        output in_valid, in1, in2,
        input  sum, out_valid
    );

    modport slave (
        input  in_valid, in1, in2,
        output sum, out_valid
    );
endinterface

// File: rtl/carry_save_adder.sv
// Registered two-operand adder: a 3:2 compressor row followed by a ripple
// carry-propagate stage, result presented as {carry_out, sum} one cycle later.
module carry_save_adder #(
    parameter int WIDTH = 32
) (
    input logic                clk,
    input logic                rst,
    carry_save_adder_if.slave  bus
);
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_c;
    logic [WIDTH:0]   w_a;
    logic [WIDTH:0]   w_b;
    logic [WIDTH:0]   w_res;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH:0]   r_sum;
    logic             r_valid;

    // Third compressor operand is constant zero, so the full adders reduce to XOR/AND.
    assign w_s = bus.in1 ^ bus.in2;
    assign w_c = bus.in1 & bus.in2;

    assign w_a        = {1'b0, w_s};
    assign w_b        = {w_c, 1'b0};
    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_ripple
        assign w_res[i] = w_a[i] ^ w_b[i] ^ w_carry[i];
        if (i < WIDTH) begin : g_carry
            assign w_carry[i+1] = (w_a[i] & w_b[i]) | (w_a[i] & w_carry[i]) | (w_b[i] & w_carry[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_sum <= w_res;
            end
        end
    end

    assign bus.sum       = r_sum;
    assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_carry_save_adder.sv
// Scoreboard bench for carry_save_adder: the driver queues expected results,
// a negedge monitor pops and checks value and 1-cycle latency.
module tb_carry_save_adder;
    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH:0] expVal;
        int             due;
    } item_t;

    logic clk;
    logic rst;
    int   cycleCount;
    int   testsRun;
    int   failCount;
    item_t sb[$];

    logic [WIDTH-1:0] vecA   [12];
    logic [WIDTH-1:0] vecB   [12];
    logic [WIDTH:0]   vecExp [12];

    carry_save_adder_if #(.WIDTH(WIDTH)) bus ();

    carry_save_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    task automatic checkOutput(input string name, input logic [WIDTH:0] actual, input logic [WIDTH:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one operand pair for the next edge and records its expected result.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH:0] expVal);
        item_t it;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in1      = a;
        bus.in2      = b;
        it.expVal    = expVal;
        it.due       = cycleCount + 1;
        sb.push_back(it);
    endtask

    always @(negedge clk) begin
        item_t it;
        if (bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                testsRun++;
                failCount++;
                $display("[TB] FAIL unexpected_out_valid: got sum %h with no pending result", bus.sum);
            end else begin
                it = sb.pop_front();
                checkOutput("result", bus.sum, it.expVal);
                testsRun++;
                if (it.due != cycleCount) begin
                    failCount++;
                    $display("[TB] FAIL latency: result at cycle %0d, expected cycle %0d", cycleCount, it.due);
                end
            end
        end else if (sb.size() > 0 && sb[0].due <= cycleCount) begin
            it = sb.pop_front();
            testsRun++;
            failCount++;
            $display("[TB] FAIL missing_out_valid: out_valid %b, expected 1 for result %h", bus.out_valid, it.expVal);
        end
    end

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [WIDTH:0]   lastExp;

        cycleCount = 0;
        testsRun   = 0;
        failCount  = 0;

        vecA[0]  = 32'h7FFFFFFF; vecB[0]  = 32'h00000001; vecExp[0]  = 33'h0_80000000;
        vecA[1]  = 32'h80000000; vecB[1]  = 32'hFFFFFFFF; vecExp[1]  = 33'h1_7FFFFFFF;
        vecA[2]  = 32'd51;       vecB[2]  = 32'hFFFFFFC9; vecExp[2]  = 33'h0_FFFFFFFC;
        vecA[3]  = 32'd50;       vecB[3]  = 32'hFFFFFFCE; vecExp[3]  = 33'h1_00000000;
        vecA[4]  = 32'hFFFFFF00; vecB[4]  = 32'd256;      vecExp[4]  = 33'h1_00000000;
        vecA[5]  = 32'd13;       vecB[5]  = 32'd7;        vecExp[5]  = 33'h0_00000014;
        vecA[6]  = 32'hFFFFFFF3; vecB[6]  = 32'hFFFFFFF9; vecExp[6]  = 33'h1_FFFFFFEC;
        vecA[7]  = 32'd250;      vecB[7]  = 32'd350;      vecExp[7]  = 33'h0_00000258;
        vecA[8]  = 32'h88CA6C00; vecB[8]  = 32'hFFFFFFE0; vecExp[8]  = 33'h1_88CA6BE0;
        vecA[9]  = 32'd0;        vecB[9]  = 32'd0;        vecExp[9]  = 33'h0_00000000;
        vecA[10] = 32'hFFFFFFFF; vecB[10] = 32'h00000001; vecExp[10] = 33'h1_00000000;
        vecA[11] = 32'hFFFFFFFF; vecB[11] = 32'hFFFFFFFF; vecExp[11] = 33'h1_FFFFFFFE;

        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in1      = 32'd5;
        bus.in2      = 32'd6;

        // Reset must override a valid request.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("reset_sum", bus.sum, '0);
            checkOutput("reset_out_valid", {{WIDTH{1'b0}}, bus.out_valid}, '0);
        end

        begin
            item_t it;
            @(posedge clk);
            #1;
            rst       = 1'b0;
            it.expVal = 33'd11;
            it.due    = cycleCount + 1;
            sb.push_back(it);
        end

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecA[i], vecB[i], vecExp[i]);
        end
        lastExp = vecExp[11];

        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in1      = 32'h12345678;
        bus.in2      = 32'h9ABCDEF0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("idle_out_valid", {{WIDTH{1'b0}}, bus.out_valid}, '0);
        checkOutput("idle_sum_hold", bus.sum, lastExp);

        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            applyStimulus(ra, rb, {1'b0, ra} + {1'b0, rb});
            if ((i % 97) == 96) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", {{WIDTH{1'b0}}, 1'b0} + sb.size(), '0);

        applyStimulus(32'd100, 32'd23, 33'd123);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in1      = 32'd1000;
        bus.in2      = 32'd2000;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_sum", bus.sum, '0);
        checkOutput("midreset_out_valid", {{WIDTH{1'b0}}, bus.out_valid}, '0);
        checkOutput("midreset_drained", {{WIDTH{1'b0}}, 1'b0} + sb.size(), '0);

        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule

// File: doc/carry_save_adder.md
Name:
carry_save_adder

Overview:
- Registered two-operand WIDTH-bit adder built on a carry-save structure.
- A row of full adders (3:2 compressors) reduces in1, in2 and a zero third operand to a sum vector S and a carry vector C without carry propagation.
- A single carry-propagate stage then resolves S + (C<<1) into a (WIDTH+1)-bit result.
- Used as a drop-in adder in the arithmetic datapath. The result is presented as {carry_out, sum}.

Parameters:
- WIDTH, 32, operand width in bits; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in1/in2 are sampled on the clock edge where in_valid=1.
- in1  input  WIDTH  first addend (two's complement or unsigned; the bit pattern is identical).
- in2  input  WIDTH  second addend.
- sum  output  WIDTH+1  registered result. sum[WIDTH] = unsigned carry-out; sum[WIDTH-1:0] = modulo-2^WIDTH sum.
- out_valid  output  1  high for one cycle when sum holds a new result.

Behaviour:
- One clock domain. Reset is synchronous and active-high: sampled only at the rising edge of clk.
- Reset values:
  - sum = 0 and out_valid = 0.
  - Any internal pipeline/valid state is cleared.
  - rst has priority over in_valid on the same edge.
- Datapath (combinational, per bit i in 0..WIDTH-1):
  - S[i] = in1[i] ^ in2[i] ^ 0.
  - C[i] = majority(in1[i], in2[i], 0).
  - The final stage adds zero-extended S and (C shifted left by 1) as a WIDTH+1-bit carry-propagate add. The carry-propagate stage is a ripple or block-ripple of full adders; the behavioural '+' operator is not permitted.
- Arithmetic rules:
  - The result equals the unsigned sum {1'b0,in1} + {1'b0,in2}.
  - The carry-out is the unsigned carry, not signed overflow.
  - No saturation: signed overflow wraps.
- Timing:
  - Latency is 1 cycle. On an edge with in_valid=1 and rst=0, sum <= in1+in2 and out_valid <= 1.
  - On an edge with in_valid=0 and rst=0, out_valid <= 0 and sum holds its previous value.
- Back-to-back in_valid pulses produce back-to-back results (throughput 1/cycle).
- Reset asserted mid-operation: the in-flight result is discarded. sum=0 and out_valid=0 on the next edge.
- There is no backpressure; the consumer must accept sum in the cycle out_valid=1.
- Operand X/Z propagation is not handled; inputs must be driven whenever in_valid=1.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, in1=5, in2=6 -> sum=0 and out_valid=0 throughout. Release rst -> next edge gives sum=11, out_valid=1.
- Signed boundaries (sum[WIDTH-1:0] read as signed):
  - in1=0x7FFFFFFF, in2=1 -> sum[31:0]=0x80000000 (INT32_MIN), carry=0.
  - in1=0x80000000, in2=0xFFFFFFFF (-1) -> sum[31:0]=0x7FFFFFFF, carry=1.
- Mixed signs:
  - 51 + (-55) -> sum[31:0]=-4, carry=0.
  - 50 + (-50) -> 0, carry=1.
  - -256 + 256 -> 0, carry=1.
  - 13 + 7 -> 20, carry=0.
  - -13 + (-7) -> -20, carry=1.
- Larger values:
  - 250 + 350 -> 600, carry=0.
  - -2000000000 + (-32) -> -2000000032, carry=1.
  - 0 + 0 -> 0, carry=0.
- Throughput: stream the above vectors on consecutive cycles with in_valid=1 -> each result appears exactly 1 cycle later, out_valid continuously high. Drop in_valid -> out_valid falls next cycle and sum holds.
- Random: 10k random in1/in2 pairs -> sum == {1'b0,in1}+{1'b0,in2} for each, with 1-cycle latency.
